// File: rtl/tt_um_unload_if.sv
// Read-back word stream from the weight unloader to a downstream loader.
// Handshake: a word (uo_data, uo_phase) transfers on a rising edge where uo_valid and ui_ready are both high; the master holds the word stable while ui_ready is low.
interface tt_um_unload_if #(
  parameter int MAX_IN_LEN = 16
);
  logic [MAX_IN_LEN-1:0] uo_data;
  logic                  uo_phase;
  logic                  uo_valid;
  logic                  ui_ready;

  modport master (output uo_data, uo_phase, uo_valid, input ui_ready);
  modport slave  (input uo_data, uo_phase, uo_valid, output ui_ready);
endinterface

// File: rtl/tt_um_unload.sv
// Weight read-back transmitter: streams the 16x8 ternary weight array column by column
// as an MSB word followed by an LSB word, each under a valid/ready handshake.
module tt_um_unload #(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 ena,
  input  logic                                 ui_start,
  input  logic [6:0]                           ui_param,
  input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0]  ui_weights,
  tt_um_unload_if.master                       bus,
  output logic                                 uo_busy,
  output logic                                 uo_done,
  output logic [1:0]                           state_dbg
);
  localparam int COL_W = $clog2(MAX_OUT_LEN);

  typedef enum logic [1:0] {IDLE = 2'd0, MSB = 2'd1, LSB = 2'd2} state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] last_col;
  logic [3:0]       last_row;

  assign state_dbg = state;

  // Bit b of weight (row i, column c) for every enabled row; rows past lr read as 0.
  function automatic logic [MAX_IN_LEN-1:0] pick_word(
    input logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] w,
    input logic [COL_W-1:0]                    c,
    input logic [3:0]                          lr,
    input logic                                b
  );
    pick_word = '0;
    for (int i = 0; i < MAX_IN_LEN; i++) begin
      if (i <= int'(lr)) pick_word[i] = w[2*(i*MAX_OUT_LEN + int'(c)) + int'(b)];
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      col          <= '0;
      last_col     <= '0;
      last_row     <= '0;
      bus.uo_data  <= '0;
      bus.uo_phase <= 1'b0;
      bus.uo_valid <= 1'b0;
      uo_busy      <= 1'b0;
      uo_done      <= 1'b0;
    end else begin
      uo_done <= 1'b0;
      if (!ena) begin
        // Abort: a partial dump is dropped, never resumed.
        state        <= IDLE;
        col          <= '0;
        bus.uo_data  <= '0;
        bus.uo_phase <= 1'b0;
        bus.uo_valid <= 1'b0;
        uo_busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ui_start) begin
              last_col     <= COL_W'(ui_param[2:0]);
              last_row     <= ui_param[6:3];
              col          <= '0;
              bus.uo_data  <= pick_word(ui_weights, '0, ui_param[6:3], 1'b1);
              bus.uo_phase <= 1'b0;
              bus.uo_valid <= 1'b1;
              uo_busy      <= 1'b1;
              state        <= MSB;
            end
          end
          MSB: begin
            if (bus.ui_ready) begin
              bus.uo_data  <= pick_word(ui_weights, col, last_row, 1'b0);
              bus.uo_phase <= 1'b1;
              state        <= LSB;
            end
          end
          LSB: begin
            if (bus.ui_ready) begin
              if (col == last_col) begin
                bus.uo_data  <= '0;
                bus.uo_phase <= 1'b0;
                bus.uo_valid <= 1'b0;
                uo_busy      <= 1'b0;
                uo_done      <= 1'b1;
                col          <= '0;
                state        <= IDLE;
              end else begin
                col          <= col + COL_W'(1);
                bus.uo_data  <= pick_word(ui_weights, col + COL_W'(1), last_row, 1'b1);
                bus.uo_phase <= 1'b0;
                state        <= MSB;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/tt_um_unload.md
# tt_um_unload

Weight read-back transmitter for the ternary matrix engine: the mirror of the weight loader. It takes the 16×8 array of 2-bit signed weights held in the datapath and streams it out column by column over the same two-phase MSB-word/LSB-word protocol the loader accepts. Each transfer is flow-controlled by a valid/ready handshake. Used for on-chip weight verification and for chaining a weight image into a second loader.

## Interface
Parameters:
- MAX_IN_LEN, 16, rows per column (width of each transmitted word)
- MAX_OUT_LEN, 8, number of columns; column counter width is $clog2(MAX_OUT_LEN)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- ena  input  1  block enable; low aborts any transfer
- ui_start  input  1  request a dump; sampled in IDLE only
- ui_param  input  7  [2:0] last column index, [6:3] last row index; sampled on accepted start
- ui_weights  input  2*MAX_IN_LEN*MAX_OUT_LEN  flattened weights; row r, column c at bits [2*(r*MAX_OUT_LEN+c)+1 : 2*(r*MAX_OUT_LEN+c)]
- ui_ready  input  1  downstream accepts current word
- uo_data  output  MAX_IN_LEN  current word; bit i = row i
- uo_phase  output  1  0 = MSB word, 1 = LSB word
- uo_valid  output  1  uo_data/uo_phase valid
- uo_busy  output  1  transfer in progress (state ≠ IDLE)
- uo_done  output  1  one-cycle pulse on completion

## Operation
- States: IDLE, MSB, LSB. Reset → IDLE.
- IDLE: if ena & ui_start: latch last_col = ui_param[2:0] and last_row = ui_param[6:3], set col = 0, load column 0 MSB word, go to MSB.
- MSB: uo_valid=1, uo_phase=0, uo_data[i] = weight[i][col][1] for i ≤ last_row, else 0. On ui_ready: load LSB word for the same col, go to LSB.
- LSB: uo_valid=1, uo_phase=1, uo_data[i] = weight[i][col][0] for i ≤ last_row, else 0. On ui_ready:
  - If col == last_col: go to IDLE and pulse uo_done.
  - Otherwise: col+1, load the next MSB word, go to MSB.
- Words are registered from ui_weights at load time. Weights are sampled per word, not snapshotted. The source must hold ui_weights stable from start until done.
- Weight bits are transmitted unmodified (01=+1, 11=−1, 00=0; 10 passed through).
- col never exceeds last_col. last_col=7 covers all 8 columns; there is no wrap.
- ena low in any state: next edge forces IDLE, uo_valid=0, col=0, no uo_done. Partial dumps are not resumed.
- ui_start while busy is ignored. ui_param changes during a transfer have no effect.
- ui_ready while uo_valid=0 is ignored.

## Timing
- Reset values: uo_data=0, uo_phase=0, uo_valid=0, uo_busy=0, uo_done=0, col=0.
- Start accepted at edge N → uo_valid=1 with column 0 MSB from N+1.
- Handshake completes on an edge where uo_valid & ui_ready. The next word is presented the following cycle. With ui_ready held high there are no idle cycles between words.
- Outputs hold unchanged while ui_ready=0, with no limit on stall length.
- Full dump of C=last_col+1 columns with ready held high: 2C valid cycles. uo_done is high for exactly one cycle, the cycle after the final LSB handshake. In that same cycle uo_valid=0 and uo_busy=0.
- A new start is accepted in the uo_done cycle. Its first word appears on the next cycle, giving one bubble minimum between dumps.
- Asynchronous reset mid-transfer clears all outputs immediately, independent of clk.

## Test plan
- Full dump, ready=1, param=7'h7F, weights[r][c] = r even ? 2'b01 : 2'b11: 16 words alternating phase 0/1; MSB words = 16'hAAAA, LSB words = 16'hFFFF; uo_done one cycle after the 16th word.
- Row masking, param={4'd3,3'd1}, all weights 2'b11: 4 words, each 16'h000F; done after the 4th word.
- Backpressure: ready low for 5 cycles on column 2 LSB. uo_data/uo_phase/uo_valid stay stable for those 5 cycles. No word is dropped or duplicated, and the total word count is still 16.
- Abort: drop ena after the column 3 MSB handshake. Next cycle uo_valid=0 and uo_busy=0, with no uo_done. A re-start then begins again at column 0 MSB.
- Start during busy and back-to-back: ui_start pulsed mid-dump is ignored. Start asserted in the uo_done cycle launches a new dump whose first word appears the next cycle.
- Loopback: feed uo_data/uo_valid into the weight loader with identical ui_param. The loader's reconstructed array equals ui_weights for all enabled rows and columns, and its done aligns with the final column.
